// File: rtl/axi_mem_fill.sv
// axi_mem_fill - AXI4 write-burst fill engine.
//
// Accepts one fill command (start address, word count, first data word,
// optional per-beat increment). It splits the command into INCR bursts
// that never cross a 4 KB page, then drives AW/W/B with one burst
// outstanding. It reports completion with a single-cycle done pulse and
// a sticky per-command error flag.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_addr             start byte address (sub-word bits ignored)
//   cmd_count            number of data words, 0 = no-op
//   cmd_pattern          first data word
//   cmd_incr             1: data increments per beat, 0: constant
//   busy                 command in progress
//   done                 one-cycle completion pulse
//   err                  any bad bresp/bid seen during the command
//   m_axi_aw*            write address channel
//   m_axi_w*             write data channel
//   m_axi_b*             write response channel
module axi_mem_fill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH/8,
    parameter int ID_WIDTH      = 12,
    parameter int MAX_BURST_LEN = 16,
    parameter int FILL_ID       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_count,
    input  logic [DATA_WIDTH-1:0] cmd_pattern,
    input  logic                  cmd_incr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int AWSIZE = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remaining_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  incr_q;
    logic [8:0]            len_q;
    logic [8:0]            beat_q;

    // Beats for the next burst: limited by words left, the burst cap and
    // the room left before the next 4 KB page boundary.
    function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [ADDR_WIDTH-1:0] r);
        int unsigned room;
        int unsigned len;
        room = (32'd4096 - 32'(a[11:0])) >> AWSIZE;
        len  = room;
        if (32'(MAX_BURST_LEN) < len) len = 32'(MAX_BURST_LEN);
        if (32'(r) < len) len = 32'(r);
        return len[8:0];
    endfunction

    logic [ADDR_WIDTH-1:0] cmd_addr_al;
    logic [ADDR_WIDTH-1:0] rem_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_step;
    logic [8:0]            first_len;
    logic [8:0]            next_len;
    logic                  resp_bad;

    assign cmd_addr_al = cmd_addr & ADDR_MASK;
    assign rem_next    = remaining_q - ADDR_WIDTH'(len_q);
    // Wraps modulo 2^ADDR_WIDTH; a burst never straddles the wrap because
    // it never straddles a 4 KB page.
    assign addr_next   = addr_q + (ADDR_WIDTH'(len_q) << AWSIZE);
    assign data_step   = data_q + DATA_WIDTH'(incr_q);
    assign first_len   = burst_len(cmd_addr_al, cmd_count);
    assign next_len    = burst_len(addr_next, rem_next);
    assign resp_bad    = (m_axi_bresp != 2'b00) || (m_axi_bid != ID_WIDTH'(FILL_ID));

    assign cmd_ready     = (state == IDLE);
    assign m_axi_awid    = ID_WIDTH'(FILL_ID);
    assign m_axi_awsize  = 3'(AWSIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;

    // Control state is reset; address/data registers only load when
    // their qualifying control is active, so they are left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr_al;
                        remaining_q <= cmd_count;
                        data_q      <= cmd_pattern;
                        incr_q      <= cmd_incr;
                        err         <= 1'b0;
                        if (cmd_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state         <= ADDR;
                            busy          <= 1'b1;
                            m_axi_awvalid <= 1'b1;
                            m_axi_awaddr  <= cmd_addr_al;
                            len_q         <= first_len;
                            m_axi_awlen   <= 8'(first_len - 9'd1);
                        end
                    end
                end
                ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        beat_q        <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    // First DATA cycle only loads the first beat; after that
                    // wvalid stays high back-to-back until wlast is taken.
                    if (!m_axi_wvalid) begin
                        m_axi_wvalid <= 1'b1;
                        m_axi_wdata  <= data_q;
                        m_axi_wlast  <= (len_q == 9'd1);
                    end else if (m_axi_wready) begin
                        data_q <= data_step;
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= RESP;
                        end else begin
                            m_axi_wdata <= data_step;
                            m_axi_wlast <= (beat_q + 9'd2 == len_q);
                            beat_q      <= beat_q + 9'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        err          <= err | resp_bad;
                        remaining_q  <= rem_next;
                        addr_q       <= addr_next;
                        if (rem_next == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state         <= ADDR;
                            m_axi_awvalid <= 1'b1;
                            m_axi_awaddr  <= addr_next;
                            len_q         <= next_len;
                            m_axi_awlen   <= 8'(next_len - 9'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_fill.sv
module tb_axi_mem_fill;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_count;
    logic [31:0] cmd_pattern;
    logic        cmd_incr;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [11:0] m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    axi_mem_fill dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_count(cmd_count), .cmd_pattern(cmd_pattern), .cmd_incr(cmd_incr),
        .busy(busy), .done(done), .err(err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] exp_data;
    logic        exp_inc;

    logic [31:0] mem [0:16383];
    logic [15:0] w_addr;

    logic        stall_en = 1'b0;
    int          b_delay  = 0;
    int          err_burst = -1;
    int          burst_idx = 0;
    logic        b_armed = 1'b0;
    int          b_wait  = 0;
    logic        b_fire  = 1'b0;
    logic        prev_aw_stall = 1'b0;
    logic        prev_w_stall  = 1'b0;
    logic [15:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [31:0] prev_wdata;
    logic        prev_wlast;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [15:0] a, input int n);
        aw_t e;
        w_t  b;
        e.addr = a;
        e.len  = 8'(n - 1);
        exp_aw.push_back(e);
        for (int i = 0; i < n; i++) begin
            b.data = exp_data;
            b.last = (i == n - 1);
            exp_w.push_back(b);
            exp_data = exp_data + 32'(exp_inc);
        end
    endtask

    // Slave: readies and B response are decided on the falling edge, then
    // the handshakes that will fire on the next rising edge are scored.
    always @(negedge clk) begin
        aw_t ea;
        w_t  ew;
        if (b_fire) begin
            m_axi_bvalid = 1'b0;
            b_fire = 1'b0;
        end
        m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (b_armed) begin
            if (b_wait == 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
                b_armed = 1'b0;
            end else begin
                b_wait--;
            end
        end
        if (prev_aw_stall) begin
            check("aw_hold_valid", m_axi_awvalid, 1'b1);
            check("aw_hold_addr", m_axi_awaddr, prev_awaddr);
            check("aw_hold_len", m_axi_awlen, prev_awlen);
        end
        if (prev_w_stall) begin
            check("w_hold_valid", m_axi_wvalid, 1'b1);
            check("w_hold_data", m_axi_wdata, prev_wdata);
            check("w_hold_last", m_axi_wlast, prev_wlast);
        end
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        prev_awaddr   = m_axi_awaddr;
        prev_awlen    = m_axi_awlen;
        prev_w_stall  = m_axi_wvalid && !m_axi_wready;
        prev_wdata    = m_axi_wdata;
        prev_wlast    = m_axi_wlast;
        if (m_axi_awvalid && m_axi_awready) begin
            w_addr = m_axi_awaddr;
            check("awsize", m_axi_awsize, 3'd2);
            check("awburst", m_axi_awburst, 2'b01);
            check("awid", m_axi_awid, 12'd0);
            if (exp_aw.size() == 0) begin
                check("aw_unexpected", 1'b1, 1'b0);
            end else begin
                ea = exp_aw.pop_front();
                check("awaddr", m_axi_awaddr, ea.addr);
                check("awlen", m_axi_awlen, ea.len);
            end
        end
        if (m_axi_wvalid && m_axi_wready) begin
            mem[w_addr[15:2]] = m_axi_wdata;
            w_addr = w_addr + 16'd4;
            check("wstrb", m_axi_wstrb, 4'hF);
            if (exp_w.size() == 0) begin
                check("w_unexpected", 1'b1, 1'b0);
            end else begin
                ew = exp_w.pop_front();
                check("wdata", m_axi_wdata, ew.data);
                check("wlast", m_axi_wlast, ew.last);
            end
            if (m_axi_wlast) begin
                b_armed = 1'b1;
                b_wait  = b_delay;
            end
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_fire = 1'b1;
            burst_idx++;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] n,
                         input logic [31:0] p, input logic inc);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        burst_idx   = 0;
        cmd_valid   = 1'b1;
        cmd_addr    = a;
        cmd_count   = n;
        cmd_pattern = p;
        cmd_incr    = inc;
        @(negedge clk);
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int k = 0;
        while (!done && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_ready_at_done"}, cmd_ready, 1'b1);
        check({tag, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
        check({tag, "_w_left"}, 64'(exp_w.size()), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_count = '0;
        cmd_pattern = '0;
        cmd_incr = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_bid = '0;
        m_axi_bresp = 2'b00;
        m_axi_bvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_wvalid", m_axi_wvalid, 1'b0);
        check("rst_bready", m_axi_bready, 1'b0);
        rst = 1'b0;

        // 1: single incrementing burst, with latency checks
        exp_data = 32'hA5A50000; exp_inc = 1'b1;
        push_burst(16'h0100, 5);
        issue(16'h0100, 16'd5, 32'hA5A50000, 1'b1);
        check("t1_awvalid_n1", m_axi_awvalid, 1'b1);
        check("t1_busy_n1", busy, 1'b1);
        check("t1_ready_busy", cmd_ready, 1'b0);
        @(negedge clk);
        check("t1_wvalid_n2", m_axi_wvalid, 1'b0);
        @(negedge clk);
        check("t1_wvalid_n3", m_axi_wvalid, 1'b1);
        wait_done("t1", 1'b0);
        for (int i = 0; i < 5; i++) check("t1_mem", mem[16'h40 + i], 32'hA5A50000 + 32'(i));

        // 2: constant pattern across three bursts
        exp_data = 32'hDEADBEEF; exp_inc = 1'b0;
        push_burst(16'h0000, 16);
        push_burst(16'h0040, 16);
        push_burst(16'h0080, 8);
        issue(16'h0000, 16'd40, 32'hDEADBEEF, 1'b0);
        wait_done("t2", 1'b0);
        for (int i = 0; i < 40; i++) check("t2_mem", mem[i], 32'hDEADBEEF);

        // 3: split at the 4 KB page boundary
        exp_data = 32'h33330000; exp_inc = 1'b1;
        push_burst(16'h0FF8, 2);
        push_burst(16'h1000, 2);
        issue(16'h0FF8, 16'd4, 32'h33330000, 1'b1);
        wait_done("t3", 1'b0);

        // 4: zero-length command
        issue(16'h0700, 16'd0, 32'h0, 1'b0);
        check("t4_done", done, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_ready", cmd_ready, 1'b1);
        check("t4_awvalid", m_axi_awvalid, 1'b0);
        @(negedge clk);
        check("t4_done_pulse", done, 1'b0);
        check("t4_busy2", busy, 1'b0);
        check("t4_ready2", cmd_ready, 1'b1);
        check("t4_awvalid2", m_axi_awvalid, 1'b0);

        // 5: stalling slave, delayed B, error on the second burst
        stall_en = 1'b1; b_delay = 10; err_burst = 1;
        exp_data = 32'h00005000; exp_inc = 1'b1;
        push_burst(16'h0300, 16);
        push_burst(16'h0340, 16);
        push_burst(16'h0380, 8);
        issue(16'h0300, 16'd40, 32'h00005000, 1'b1);
        wait_done("t5", 1'b1);
        b_delay = 0; err_burst = -1;
        exp_data = 32'h00000077; exp_inc = 1'b0;
        push_burst(16'h0500, 1);
        issue(16'h0500, 16'd1, 32'h00000077, 1'b0);
        check("t5b_err_cleared", err, 1'b0);
        wait_done("t5b", 1'b0);
        stall_en = 1'b0;

        // 6: reset while the third beat is on the bus
        exp_data = 32'h600D0000; exp_inc = 1'b1;
        push_burst(16'h0400, 16);
        issue(16'h0400, 16'd16, 32'h600D0000, 1'b1);
        k = 0;
        while (!(m_axi_wvalid && m_axi_wdata == 32'h600D0002) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_beat3_seen", m_axi_wdata, 32'h600D0002);
        #1;
        rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        b_armed = 1'b0;
        @(negedge clk);
        check("t6_awvalid", m_axi_awvalid, 1'b0);
        check("t6_wvalid", m_axi_wvalid, 1'b0);
        check("t6_bready", m_axi_bready, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        exp_data = 32'hC0DE0000; exp_inc = 1'b1;
        push_burst(16'h0200, 2);
        issue(16'h0200, 16'd2, 32'hC0DE0000, 1'b1);
        wait_done("t6b", 1'b0);
        check("t6_mem0", mem[16'h80], 32'hC0DE0000);
        check("t6_mem1", mem[16'h81], 32'hC0DE0001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_fill.md
Name: axi_mem_fill

Overview:
Command-driven AXI4 write-burst sequencer that initialises or patterns the AXI SRAM slave. It takes one fill command (start address, word count, data pattern, optional increment), splits it into INCR bursts, and drives the AW/W/B channels to completion. It then reports done and error status. It sits between the test/config logic and the SRAM write port, used for memory init, scrub and pattern loading.

Parameters:
DATA_WIDTH, 32, AXI data width in bits
ADDR_WIDTH, 16, AXI byte-address width
STRB_WIDTH, DATA_WIDTH/8, wstrb width; must be a power of two
ID_WIDTH, 12, AXI ID width
MAX_BURST_LEN, 16, maximum beats per burst; legal range 1..256
FILL_ID, 0, awid driven on every burst and expected on bid

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0)
cmd_count  in  ADDR_WIDTH  number of data words; 0 = no-op
cmd_pattern  in  DATA_WIDTH  first data word
cmd_incr  in  1  1: data +1 per beat (mod 2^DATA_WIDTH); 0: constant
busy  out  1  command in progress
done  out  1  one-cycle pulse at completion
err  out  1  sticky per command: any bresp!=0 or bid!=FILL_ID; cleared on next cmd accept
m_axi_awid/awaddr/awlen/awsize/awburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
m_axi_awvalid  out  1 ; m_axi_awready  in  1
m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/STRB_WIDTH/1  write data
m_axi_wvalid  out  1 ; m_axi_wready  in  1
m_axi_bid/bresp  in  ID_WIDTH/2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. After the reset edge: state IDLE; awvalid, wvalid, bready, busy, done, err = 0; cmd_ready = 1. Reset mid-operation abandons the burst immediately. rst must be shared with the slave.
- Constant fields: awid=FILL_ID, awsize=log2(STRB_WIDTH), awburst=2'b01 (INCR), wstrb=all ones.
- cmd_ready = (state==IDLE). All other outputs are registered.
- IDLE: on accept, latch addr, remaining=cmd_count, data=cmd_pattern, incr; clear err.
  - If count==0: done=1 next cycle; stay IDLE; busy stays 0.
  - Otherwise go to ADDR; busy=1 from the next cycle.
- ADDR: burst len L = min(remaining, MAX_BURST_LEN, (4096 - addr%4096)/STRB_WIDTH), so no burst crosses a 4 KB boundary.
  - awvalid=1 from the first cycle in ADDR; awaddr=addr, awlen=L-1.
  - awaddr/awlen are held stable until awready.
  - On awvalid&&awready: awvalid=0, go to DATA.
- DATA: wvalid=1 starting the cycle after AW handshake; wdata=current data; wlast=1 on beat L.
  - On each wvalid&&wready: advance data by incr; next beat presented the following cycle with no bubble required.
  - wdata/wlast are held stable while wready=0.
  - After beat L is accepted: wvalid=0, go to RESP.
- RESP: bready=1.
  - On bvalid: err |= (bresp!=0 || bid!=FILL_ID); remaining -= L; addr += L*STRB_WIDTH (mod 2^ADDR_WIDTH, wraps).
  - If remaining==0: go to IDLE, done=1 for one cycle, busy=0 in the same cycle.
  - Otherwise go to ADDR.
- Ordering: one burst outstanding; AW always precedes W.
- Transfer latency: cmd accept at cycle N gives awvalid at N+1. With a zero-wait slave, the first wvalid is at N+3.
- cmd_valid asserted while busy is ignored; no queueing.
- Address wrap past 2^ADDR_WIDTH-1 continues from 0. Bursts never straddle the wrap because 4 KB divides 2^ADDR_WIDTH for ADDR_WIDTH>=12.

Test Plan:
1. addr 0x0100, count 5, pattern 0xA5A50000, incr=1 → one AW: awaddr 0x0100, awlen 4, awsize 2, awburst 01. W data 0xA5A50000..0xA5A50004, wlast on beat 5. done pulse after B. SRAM readback of words 0x40..0x44 matches.
2. addr 0x0000, count 40, incr=0, pattern 0xDEADBEEF → three bursts: awaddr 0x0000/0x0040/0x0080, awlen 15/15/7. All 40 words read back 0xDEADBEEF.
3. addr 0x0FF8, count 4 → two bursts: awaddr 0x0FF8 awlen 1, then 0x1000 awlen 1. No burst crosses 0x1000.
4. count 0 → no AW issued; done=1 exactly one cycle after accept; busy stays 0; cmd_ready high throughout.
5. Slave model with random awready/wready stalls, bvalid delayed 10 cycles, bresp=2'b10 on burst 2 of 3 → AW/W fields stable while stalled, no beat lost or duplicated, err=1 at done. Next command (count 1) clears err to 0.
6. Assert rst for 1 cycle during beat 3 of a 16-beat burst → next cycle awvalid=wvalid=bready=busy=done=err=0, cmd_ready=1. A new command (addr 0x0200, count 2) then completes normally.
